// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
//
// Shares one AHB-Lite Master application port between NUM_REQ requesters.
// Round-robin arbitration, grant locked for the duration of a burst, and
// pipelined address/data phases: each beat's write data is presented to the
// Master one cycle after its address. BUSY beats are inserted while a burst
// owner stalls. Read data and error responses are routed back to the
// requester that owns the beat currently in its data phase.
//
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   req_valid/opcode/addr/wdata/last   per-requester beat request
//   req_ready               beat accepted this cycle (one-hot)
//   rsp_valid               data phase of this requester's beat completed
//   rsp_rdata, rsp_error    shared response, qualified by rsp_valid
//   owner                   index of current/last granted requester
//   m_enable/new_trans/busy/opcode/addr/data_in   to the Master
//   m_data_out/data_valid/error/wait              from the Master
// ---------------------------------------------------------------------------
module ahb_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 2) ? 2 : 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [4*NUM_REQ-1:0]  req_opcode,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [IDW-1:0]        owner,
    output logic                  m_enable,
    output logic                  m_new_trans,
    output logic                  m_busy,
    output logic [3:0]            m_opcode,
    output logic [31:0]           m_addr,
    output logic [31:0]           m_data_in,
    input  logic [31:0]           m_data_out,
    input  logic                  m_data_valid,
    input  logic                  m_error,
    input  logic                  m_wait
);

    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, rr_nxt;

    // Data-phase register: the beat whose write data / response is in flight.
    logic           dphase_vld;
    logic [IDW-1:0] dphase_owner;
    logic [31:0]    dphase_wdata;

    // Last values driven to the Master; used for hold and wait-freeze.
    logic           en_q, nt_q, busy_q;
    logic [3:0]     op_q;
    logic [31:0]    addr_q;

    logic [3:0]     op_arr    [NUM_REQ];
    logic [31:0]    addr_arr  [NUM_REQ];
    logic [31:0]    wdata_arr [NUM_REQ];

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    logic           issue, complete, abort;
    logic           beat_burst, beat_last;

    // The Master's data_valid is redundant with m_wait for completion.
    logic unused_m_data_valid;
    assign unused_m_data_valid = m_data_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]    = req_opcode[4*g +: 4];
        assign addr_arr[g]  = req_addr[32*g +: 32];
        assign wdata_arr[g] = req_wdata[32*g +: 32];
    end

    function automatic logic [IDW-1:0] inc_idx(input logic [IDW-1:0] i);
        return (32'(i) >= NREQ_U - 1) ? '0 : i + IDW'(1);
    endfunction

    // Winner selection: locked owner during a burst, otherwise the first
    // valid requester scanning upward from rr_ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = owner;
        cand      = '0;
        if (state == BURST) begin
            win_found = req_valid[owner];
        end else begin
            for (int unsigned k = 0; k < NREQ_U; k++) begin
                cand = IDW'((32'(rr_ptr) + k) % NREQ_U);
                if (!win_found && req_valid[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    assign issue      = win_found & ~m_wait & ~HRESET;
    assign complete   = dphase_vld & ~m_wait & ~HRESET;
    assign abort      = complete & m_error & (state == BURST);
    assign beat_burst = op_arr[win_idx][3];
    assign beat_last  = ~beat_burst | req_last[win_idx];

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            dphase_vld   <= 1'b0;
            dphase_owner <= '0;
            dphase_wdata <= '0;
            en_q         <= 1'b0;
            nt_q         <= 1'b0;
            busy_q       <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            en_q   <= m_enable;
            nt_q   <= m_new_trans;
            busy_q <= m_busy;
            op_q   <= m_opcode;
            addr_q <= m_addr;
            if (issue) begin
                owner        <= win_idx;
                dphase_vld   <= 1'b1;
                dphase_owner <= win_idx;
                dphase_wdata <= wdata_arr[win_idx];
            end else if (complete) begin
                dphase_vld <= 1'b0;
            end
        end
    end

    // Next-state logic. An erroring burst completion overrides the normal
    // transition: the lock is dropped even if the owner issued a beat in the
    // same cycle (that beat still completes through the data-phase register).
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        if (!m_wait) begin
            if (issue) begin
                state_nxt = beat_last ? SINGLE : BURST;
            end else if (state != BURST) begin
                state_nxt = IDLE;
            end
            if (issue && beat_last) begin
                rr_nxt = inc_idx(win_idx);
            end
            if (abort) begin
                state_nxt = IDLE;
                rr_nxt    = inc_idx(owner);
            end
        end
    end

    // Output logic
    always_comb begin
        m_enable    = en_q;
        m_new_trans = nt_q;
        m_busy      = busy_q;
        m_opcode    = op_q;
        m_addr      = addr_q;
        req_ready   = '0;
        rsp_valid   = '0;

        if (issue) begin
            m_enable    = 1'b1;
            m_new_trans = (state != BURST);
            m_busy      = 1'b0;
            m_opcode    = op_arr[win_idx];
            m_addr      = addr_arr[win_idx];
            req_ready[win_idx] = 1'b1;
        end else if (state == BURST) begin
            // Owner stalled mid-burst: BUSY beat, address/opcode held.
            m_enable    = 1'b1;
            m_new_trans = 1'b0;
            m_busy      = 1'b1;
        end else if (dphase_vld) begin
            m_enable    = 1'b1;
            m_new_trans = 1'b0;
            m_busy      = 1'b0;
            m_opcode    = {1'b0, op_q[2:0]};
        end else begin
            m_enable    = 1'b0;
        end

        // Master stall: everything toward it freezes.
        if (m_wait) begin
            m_enable    = en_q;
            m_new_trans = nt_q;
            m_busy      = busy_q;
            m_opcode    = op_q;
            m_addr      = addr_q;
        end

        if (complete) begin
            rsp_valid[dphase_owner] = 1'b1;
        end
        rsp_rdata = complete ? m_data_out : '0;
        rsp_error = complete & m_error;
        m_data_in = dphase_wdata;

        if (HRESET) begin
            m_enable    = 1'b0;
            m_new_trans = 1'b0;
            m_busy      = 1'b0;
            m_opcode    = '0;
            m_addr      = '0;
            m_data_in   = '0;
            req_ready   = '0;
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter (NUM_REQ=2): directed scenarios
// plus a randomized run against a transaction-level reference model.
module tb_ahb_master_arbiter;
    localparam int NUM_REQ = 2;
    localparam int IDW     = 1;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  req_valid;
    logic [7:0]  req_opcode;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [0:0]  owner;
    logic        m_enable, m_new_trans, m_busy;
    logic [3:0]  m_opcode;
    logic [31:0] m_addr, m_data_in, m_data_out;
    logic        m_data_valid, m_error, m_wait;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] ctl;
    assign ctl = {req_ready, rsp_valid, m_enable, m_new_trans, m_busy};

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_last(req_last), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .owner(owner), .m_enable(m_enable), .m_new_trans(m_new_trans),
        .m_busy(m_busy), .m_opcode(m_opcode), .m_addr(m_addr),
        .m_data_in(m_data_in), .m_data_out(m_data_out),
        .m_data_valid(m_data_valid), .m_error(m_error), .m_wait(m_wait)
    );

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] wd, input logic l);
        req_valid[i]          = v;
        req_opcode[4*i +: 4]  = op;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = wd;
        req_last[i]           = l;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_opcode = '0; req_addr = '0; req_wdata = '0; req_last = '0;
        m_data_out = '0; m_data_valid = 1'b1; m_error = 1'b0; m_wait = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        clear_inputs();
        set_req(0, 1'b1, 4'h6, 32'h1, 32'h1234, 1'b0);
        set_req(1, 1'b1, 4'h2, 32'h2, 32'h5678, 1'b0);
        for (int c = 0; c < 2; c++) begin
            cyc();
            #4;
            n_tests++;
            if (ctl !== 7'b0 || owner !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctl c%0d got ctl=%b owner=%0d exp ctl=0000000 owner=0", c, ctl, owner);
            end
            n_tests++;
            if (m_opcode !== 4'h0 || m_addr !== 32'h0 || m_data_in !== 32'h0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_data c%0d got op=%h addr=%h din=%h rdata=%h err=%b exp all 0",
                         c, m_opcode, m_addr, m_data_in, rsp_rdata, rsp_error);
            end
        end
        cyc();
        HRESET = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(0, 1'b1, 4'h6, 32'h1, 32'hAABBCCDD, 1'b0);
        #4;
        n_tests++;
        if (ctl !== 7'b0100110 || m_opcode !== 4'h6 || m_addr !== 32'h1) begin
            n_fail++;
            $display("FAIL single_issue got ctl=%b op=%h addr=%h exp ctl=0100110 op=6 addr=1", ctl, m_opcode, m_addr);
        end
        cyc();
        req_valid = '0;
        #4;
        n_tests++;
        if (ctl !== 7'b0001100 || m_data_in !== 32'hAABBCCDD || rsp_error !== 1'b0 || m_opcode !== 4'h6) begin
            n_fail++;
            $display("FAIL single_dphase got ctl=%b din=%h err=%b op=%h exp ctl=0001100 din=aabbccdd err=0 op=6",
                     ctl, m_data_in, rsp_error, m_opcode);
        end
        cyc();
        #4;
        n_tests++;
        if (ctl !== 7'b0000000 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got ctl=%b owner=%0d exp ctl=0000000 owner=0", ctl, owner);
        end
        cyc();
    endtask

    task automatic test_round_robin();
        int prev;
        logic [31:0] exp_rd;
        do_reset();
        set_req(0, 1'b1, 4'h2, 32'h100, 32'h0, 1'b0);
        set_req(1, 1'b1, 4'h2, 32'h200, 32'h0, 1'b0);
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req_valid = '0;
            exp_rd = (prev == 0) ? 32'h11111111 : 32'h22222222;
            m_data_out = exp_rd;
            #4;
            n_tests++;
            if (k < 4 && (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || m_new_trans !== 1'b1
                          || m_addr !== ((k % 2 == 0) ? 32'h100 : 32'h200))) begin
                n_fail++;
                $display("FAIL rr_grant k%0d got ready=%b nt=%b addr=%h", k, req_ready, m_new_trans, m_addr);
            end
            if (prev >= 0) begin
                n_tests++;
                if (rsp_valid !== ((prev == 0) ? 2'b01 : 2'b10) || rsp_rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rr_rsp k%0d got rsp=%b rdata=%h exp owner=%0d rdata=%h", k, rsp_valid, rsp_rdata, prev, exp_rd);
                end
            end
            prev = k % 2;
            cyc();
        end
    endtask

    task automatic test_burst_busy();
        logic [6:0]  ec [6] = '{7'b1000110, 7'b1010100, 7'b0010101, 7'b1000100, 7'b0110110, 7'b0001100};
        logic [31:0] ea [6] = '{32'h4, 32'h5, 32'h5, 32'h6, 32'h100, 32'h100};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin set_req(1, 1'b1, 4'hD, 32'h4, 32'hB0000004, 1'b0); set_req(0, 1'b0, 4'h2, 32'h100, 32'h0, 1'b0); end
                1: begin set_req(1, 1'b1, 4'hD, 32'h5, 32'hB0000005, 1'b0); req_valid[0] = 1'b1; end
                2: req_valid[1] = 1'b0;
                3: set_req(1, 1'b1, 4'hD, 32'h6, 32'hB0000006, 1'b1);
                4: req_valid[1] = 1'b0;
                default: req_valid[0] = 1'b0;
            endcase
            #4;
            n_tests++;
            if (ctl !== ec[c] || m_addr !== ea[c]) begin
                n_fail++;
                $display("FAIL burst_c%0d got ctl=%b addr=%h exp ctl=%b addr=%h", c, ctl, m_addr, ec[c], ea[c]);
            end
            if (c == 1 || c == 2) begin
                n_tests++;
                if (m_opcode !== 4'hD || m_data_in !== ((c == 1) ? 32'hB0000004 : 32'hB0000005)) begin
                    n_fail++;
                    $display("FAIL burst_hold_c%0d got op=%h din=%h", c, m_opcode, m_data_in);
                end
            end
            cyc();
        end
    endtask

    task automatic test_wait_states();
        logic [6:0] ec [5] = '{7'b0100110, 7'b0000110, 7'b0000110, 7'b1001110, 7'b0010100};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: set_req(0, 1'b1, 4'h2, 32'h40, 32'h5A5A5A5A, 1'b0);
                1: begin req_valid[0] = 1'b0; set_req(1, 1'b1, 4'h2, 32'h80, 32'h0, 1'b0); m_wait = 1'b1; end
                2: m_wait = 1'b1;
                3: begin m_wait = 1'b0; m_data_out = 32'hABCDEF00; end
                default: begin req_valid = '0; m_data_out = 32'h12345678; end
            endcase
            #4;
            n_tests++;
            if (ctl !== ec[c]) begin
                n_fail++;
                $display("FAIL wait_ctl_c%0d got %b exp %b", c, ctl, ec[c]);
            end
            if (c == 1 || c == 2) begin
                n_tests++;
                if (m_addr !== 32'h40 || m_opcode !== 4'h2 || m_data_in !== 32'h5A5A5A5A) begin
                    n_fail++;
                    $display("FAIL wait_frozen_c%0d got addr=%h op=%h din=%h exp 40/2/5a5a5a5a", c, m_addr, m_opcode, m_data_in);
                end
            end
            if (c >= 3) begin
                n_tests++;
                if (rsp_rdata !== ((c == 3) ? 32'hABCDEF00 : 32'h12345678)) begin
                    n_fail++;
                    $display("FAIL wait_rdata_c%0d got %h", c, rsp_rdata);
                end
            end
            cyc();
        end
        m_wait = 1'b0;
    endtask

    task automatic test_burst_error();
        logic [6:0] ec [5] = '{7'b0100110, 7'b0101100, 7'b1001110, 7'b0110110, 7'b0001100};
        logic       ee [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin set_req(0, 1'b1, 4'hA, 32'h10, 32'h0, 1'b0); set_req(1, 1'b1, 4'h2, 32'h20, 32'h0, 1'b0); end
                1: begin set_req(0, 1'b1, 4'hA, 32'h14, 32'h0, 1'b0); m_error = 1'b1; end
                2: begin set_req(0, 1'b1, 4'hA, 32'h10, 32'h0, 1'b0); m_error = 1'b0; end
                3: begin set_req(0, 1'b1, 4'hA, 32'h10, 32'h0, 1'b1); req_valid[1] = 1'b0; end
                default: req_valid = '0;
            endcase
            #4;
            n_tests++;
            if (ctl !== ec[c] || rsp_error !== ee[c]) begin
                n_fail++;
                $display("FAIL berr_c%0d got ctl=%b err=%b exp ctl=%b err=%b", c, ctl, rsp_error, ec[c], ee[c]);
            end
            cyc();
        end
    endtask

    typedef struct { int own; logic [31:0] wdata; } beat_t;

    task automatic test_random();
        beat_t       dq[$];
        int          md_rr, md_lock_own, md_last, grant;
        bit          md_lock, aborted;
        logic        e_en, e_nt, e_busy;
        logic [3:0]  e_op;
        logic [31:0] e_addr, e_din, e_rd;
        logic [1:0]  x_ready, x_rsp;
        bit          have [NUM_REQ];
        int          left [NUM_REQ];
        bit          gburst [NUM_REQ];
        logic [2:0]  gcode [NUM_REQ];

        do_reset();
        md_rr = 0; md_lock = 0; md_lock_own = 0; md_last = 0;
        e_en = 0; e_nt = 0; e_busy = 0; e_op = '0; e_addr = '0; e_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin have[i] = 0; left[i] = 0; gburst[i] = 0; gcode[i] = '0; end

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!have[i] && $urandom_range(0, 3) != 0) begin
                    have[i] = 1;
                    if (left[i] == 0) begin
                        gburst[i] = 1'($urandom_range(0, 1));
                        left[i]   = gburst[i] ? int'($urandom_range(2, 4)) : 1;
                        gcode[i]  = 3'($urandom_range(0, 7));
                    end
                    set_req(i, 1'b1, {gburst[i], gcode[i]}, $urandom, $urandom,
                            gburst[i] ? (left[i] == 1) : 1'($urandom_range(0, 1)));
                end
                req_valid[i] = have[i];
            end
            m_wait     = ($urandom_range(0, 4) == 0);
            m_error    = ($urandom_range(0, 7) == 0);
            m_data_out = $urandom;
            #4;

            // Reference: expected behaviour for this cycle.
            x_ready = '0; x_rsp = '0; grant = -1;
            if (!m_wait) begin
                if (md_lock) begin
                    if (req_valid[md_lock_own]) grant = md_lock_own;
                end else begin
                    for (int k = 0; k < NUM_REQ; k++)
                        if (grant < 0 && req_valid[(md_rr + k) % NUM_REQ]) grant = (md_rr + k) % NUM_REQ;
                end
                if (grant >= 0) x_ready[grant] = 1'b1;
                if (dq.size() > 0) x_rsp[dq[0].own] = 1'b1;
                if (grant >= 0) begin
                    e_en = 1; e_nt = !md_lock; e_busy = 0;
                    e_op = req_opcode[4*grant +: 4]; e_addr = req_addr[32*grant +: 32];
                end else if (md_lock) begin
                    e_en = 1; e_nt = 0; e_busy = 1;
                end else if (dq.size() > 0) begin
                    e_en = 1; e_nt = 0; e_busy = 0; e_op[3] = 1'b0;
                end else begin
                    e_en = 0;
                end
            end
            e_rd = (x_rsp != 0) ? m_data_out : 32'h0;

            n_tests++;
            if ({req_ready, rsp_valid, m_enable, m_new_trans, m_busy, m_opcode} !== {x_ready, x_rsp, e_en, e_nt, e_busy, e_op}) begin
                n_fail++;
                $display("FAIL rand_ctl n%0d got rdy=%b rsp=%b en=%b nt=%b busy=%b op=%h exp rdy=%b rsp=%b en=%b nt=%b busy=%b op=%h",
                         n, req_ready, rsp_valid, m_enable, m_new_trans, m_busy, m_opcode, x_ready, x_rsp, e_en, e_nt, e_busy, e_op);
            end
            n_tests++;
            if (m_addr !== e_addr || m_data_in !== e_din) begin
                n_fail++;
                $display("FAIL rand_addr n%0d got addr=%h din=%h exp addr=%h din=%h", n, m_addr, m_data_in, e_addr, e_din);
            end
            n_tests++;
            if (rsp_rdata !== e_rd || rsp_error !== ((x_rsp != 0) && m_error) || owner !== 1'(md_last)) begin
                n_fail++;
                $display("FAIL rand_rsp n%0d got rdata=%h err=%b owner=%0d exp rdata=%h err=%b owner=%0d",
                         n, rsp_rdata, rsp_error, owner, e_rd, (x_rsp != 0) && m_error, md_last);
            end

            // Reference: commit the clock edge.
            if (!m_wait) begin
                aborted = (dq.size() > 0) && m_error && md_lock;
                if (dq.size() > 0) void'(dq.pop_front());
                if (grant >= 0) begin
                    dq.push_back('{grant, req_wdata[32*grant +: 32]});
                    e_din   = req_wdata[32*grant +: 32];
                    md_last = grant;
                    if (!req_opcode[4*grant + 3] || req_last[grant]) begin
                        md_rr = (grant + 1) % NUM_REQ; md_lock = 0;
                    end else begin
                        md_lock = 1; md_lock_own = grant;
                    end
                    have[grant] = 0;
                    left[grant] = left[grant] - 1;
                end
                if (aborted) begin
                    md_lock = 0; md_rr = (md_lock_own + 1) % NUM_REQ;
                end
            end
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        HRESET = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_burst_busy();
        test_wait_states();
        test_burst_error();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
Shares the single AHB-Lite Master application port between NUM_REQ requesters. Performs round-robin arbitration, locks the grant for the duration of a burst, and schedules address and data phases so that each beat's write data reaches the Master one cycle after its address. It inserts BUSY beats when the burst owner stalls, and routes read data and error responses back to the owning requester. It sits between the application clients and the Master, and the Master is its only downstream.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
IDW, 1, width of owner index (clog2(NUM_REQ), minimum 1)

Ports:
HCLK  in  1  system clock; all logic on rising edge
HRESET  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  beat request per requester
req_opcode  in  4*NUM_REQ  per requester: bit3 = burst, bits2:0 = function code (load/store byte/half/word, UART)
req_addr  in  32*NUM_REQ  beat address
req_wdata  in  32*NUM_REQ  beat write data, sampled together with the address
req_last  in  NUM_REQ  last beat of a burst; ignored when bit3 = 0
req_ready  out  NUM_REQ  beat accepted this cycle (req_valid & req_ready)
rsp_valid  out  NUM_REQ  data phase of this requester's beat completed
rsp_rdata  out  32  read data (shared; qualified by rsp_valid)
rsp_error  out  1  error response (shared; qualified by rsp_valid)
owner  out  IDW  index of current/last granted requester
m_enable, m_new_trans, m_busy  out  1 each  to Master enable/new_trans/busy
m_opcode  out  4  to Master opcode
m_addr  out  32  to Master addr
m_data_in  out  32  to Master data_in
m_data_out  in  32  from Master data_out
m_data_valid, m_error, m_wait  in  1 each  from Master

Behaviour:
- Reset (HRESET=1 at a rising edge): state=IDLE, rr_ptr=0, owner=0, dphase_vld=0. All m_* outputs, req_ready, rsp_valid and rsp_error are 0; rsp_rdata is 0. In-flight beats are dropped and produce no response.
- States:
  - IDLE: no grant held.
  - SINGLE: the granted beat is a non-burst beat.
  - BURST: grant locked to owner until its req_last beat is accepted.
- Arbitration, in IDLE or after a SINGLE/last-burst beat is accepted: pick the first requester with req_valid, scanning from rr_ptr upward with wrap. Same-cycle decision, no bubble.
  - rr_ptr is set to winner+1 (mod NUM_REQ) when the winner's single beat or req_last beat is accepted.
- Beat issue (m_wait=0): drive m_enable=1, m_opcode=req_opcode, m_addr=req_addr, and assert req_ready for the winner only.
  - m_new_trans=1 for a single beat or the first beat of a burst; 0 for continuation beats.
  - req_wdata is captured into the data-phase register along with the owner id, and dphase_vld=1.
- Data phase: in the cycle after issue, m_data_in = captured wdata. Completion occurs on the first cycle of that phase with m_wait=0. At completion:
  - rsp_valid[dphase_owner]=1 for exactly one cycle.
  - rsp_rdata = m_data_out.
  - rsp_error = m_error.
- Data-only cycle: dphase_vld=1 and no new beat. Drive m_enable=1, m_new_trans=0, m_opcode[3]=0, m_busy=0, and hold m_addr.
- Nothing pending: m_enable=0 and all other m_* outputs hold their values.
- BUSY: in BURST with owner req_valid=0, drive m_busy=1, m_enable=1, m_new_trans=0. Hold m_opcode and m_addr. No req_ready. Other requesters are not granted.
- Wait: while m_wait=1, all m_* outputs are frozen, req_ready=0, and rsp_valid=0. Arbitration is frozen.
- Error: when m_error is seen at completion during BURST, the burst is aborted.
  - The response carries rsp_error=1.
  - State goes to IDLE, the lock is released, and rr_ptr advances past the owner.
  - The address-phase beat accepted in the same cycle still completes normally.
  - The owner restarts with a new first beat.
- Simultaneous events:
  - Completion and a new issue in the same cycle are both allowed (pipelined).
  - A response for the old owner and req_ready for the new owner may occur in the same cycle.
- A new burst beat (opcode[3]=1) from a non-owner is never accepted while BURST is locked.

Test Plan:
- Reset: HRESET=1 for 2 cycles with req_valid=2'b11 -> all m_* outputs 0, req_ready=0, rsp_valid=0, owner=0.
- Single write, req0: store_word, addr=1, wdata=AABBCCDD, m_wait=0 -> cycle 0: m_new_trans=1, m_opcode=4'h6, m_addr=1, req_ready[0]=1; cycle 1: m_data_in=AABBCCDD, rsp_valid[0]=1, rsp_error=0.
- Round-robin: both requesters continuously issue single load_word -> grants alternate 0,1,0,1. Read data 11111111 returns with rsp_valid[0], and 22222222 returns with rsp_valid[1].
- Burst lock with BUSY: req1 issues a 3-beat store_halfword burst (opcode 4'hD, addr 4,5,6) and drops req_valid for 1 cycle after beat 2; req0 is valid throughout.
  - Expected: m_busy=1 for one cycle and req0 stays blocked.
  - After req_last is accepted, req0 is granted next.
- Wait states: m_wait=1 for 2 cycles during the data phase of a read -> m_* outputs held constant; rsp_valid rises only once, after m_wait falls, with rsp_rdata=ABCDEF00.
- Error in burst: m_error=1 at completion of beat 1 of req0's burst -> rsp_error=1 with rsp_valid[0]; state returns to IDLE; req1 is granted on the next cycle.
